dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter for the data memory's shared load/store port (address, byte-size, write data, write/read strobes, combinational read data). It sits between the core's load/store unit (requester 0) and a secondary master such as a debug/DMA engine (requester 1). It grants one access per cycle, registers read data back to the winner, and supports weighted fairness plus a requester-1 lock for atomic read-modify-write sequences.

## Interface
- `CORE_BURST`, default 4: maximum consecutive contested grants to requester 0 before requester 1 must win one (valid range 1..15).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `m0_req` / `m1_req`  in  1  access request, held until granted.
- `m0_addr` / `m1_addr`  in  32  byte address.
- `m0_bytes` / `m1_bytes`  in  2  size: 00 = word, 01 = byte, 10 = halfword, 11 = word.
- `m0_wdata` / `m1_wdata`  in  32  store data, LSB-aligned.
- `m0_we` / `m1_we`  in  1  1 = store, 0 = load (qualified by req).
- `m1_lock`  in  1  requester 1 asks to keep ownership after its grant.
- `m0_gnt` / `m1_gnt`  out  1  access accepted this cycle (combinational).
- `m0_rvalid` / `m1_rvalid`  out  1  load data valid, one cycle after a load grant.
- `rdata`  out  32  registered load data, shared by both requesters.
- `mem_addr`  out  32  to memory.
- `mem_bytes`  out  2  to memory.
- `mem_wdata`  out  32  to memory.
- `mem_we`  out  1  to memory.
- `mem_re`  out  1  to memory.
- `mem_rdata`  in  32  combinational read data from memory.

## Operation
- State: `burst_cnt` (4 bits), `locked` (1 bit), `last_rd_owner` (2 bits, one-hot or none).
- Grant rules, evaluated combinationally each cycle. Priority runs top to bottom.
  - `locked`=1: only requester 1 may be granted; `m0_gnt`=0 even if `m0_req`.
  - Exactly one requester requests: it is granted.
  - Both request and `burst_cnt` < `CORE_BURST`: grant requester 0.
  - Both request and `burst_cnt` = `CORE_BURST`: grant requester 1.
  - Neither requests: no grant.
- Counter update.
  - Clear `burst_cnt` to 0 on a contested grant to requester 1.
  - Clear it to 0 on any cycle in which `m1_req`=0.
  - Increment it on a contested grant to requester 0.
  - It never exceeds `CORE_BURST`.
- Lock update.
  - `locked` is set when requester 1 is granted with `m1_lock`=1.
  - It clears on the first cycle with `m1_lock`=0; that cycle's grant is still evaluated under `locked`=1.
  - While locked, if `m1_req`=0 the memory port idles.
- Memory drive.
  - The granted requester's addr/bytes/wdata pass straight through.
  - `mem_we` = gnt & we; `mem_re` = gnt & ~we.
  - With no grant, `mem_we`=`mem_re`=0 and `mem_addr`/`mem_bytes`/`mem_wdata` = requester 0's values. This keeps the core path mux-free when idle.
- Read return.
  - On a load grant, capture `mem_rdata` into `rdata` at the clock edge.
  - Next cycle, assert the winner's `mX_rvalid` for exactly one cycle.
  - `rdata` holds its value until the next load grant.
- Stores produce no response; the grant is the completion.
- Writes to the UART address are passed through unchanged; the memory handles peripheral decode.

## Timing
- Reset (`reset`=0 at a clk edge) sets: `burst_cnt`=0, `locked`=0, `m0_rvalid`=`m1_rvalid`=0, `rdata`=0.
- While `reset`=0, both gnt outputs are forced 0 and `mem_we`=`mem_re`=0.
- Reset mid-lock drops the lock. A load granted in the cycle reset is asserted returns no rvalid.
- Grant latency is 0 cycles. Load data latency is 1 cycle after grant.
- Throughput is one access per cycle. Back-to-back loads from alternating requesters each get their own rvalid on consecutive cycles.
- Store followed by load to the same address on the next cycle returns the stored data; the memory write commits at the grant edge.
- A requester must hold req and payload stable until gnt. Dropping req before gnt is allowed; the request is simply abandoned.

## Test plan
- Reset, then `m0_req` load from 0x10 with memory word 0xDEADBEEF.
  - `m0_gnt`=1 same cycle, `mem_re`=1.
  - Next cycle `m0_rvalid`=1, `rdata`=0xDEADBEEF; `m1_rvalid`=0.
- Both requesters hold loads continuously with `CORE_BURST`=4.
  - Grant sequence 0,0,0,0,1,0,0,0,0,1.
  - `burst_cnt` returns to 0 after each requester-1 grant.
- `m1_req`+`m1_lock` for 3 cycles (load, store, load) while `m0_req`=1 throughout.
  - `m0_gnt`=0 for all 3 cycles and the cycle where lock drops.
  - Requester 0 is granted the following cycle.
- Requester 1 stores byte 0xAB to 0x21, then requester 0 loads word 0x20 next cycle.
  - `mem_we`=1 with `mem_bytes`=01.
  - The load returns byte 1 = 0xAB.
- Assert `reset`=0 while `locked`=1 and a load was just granted.
  - Next cycle: no rvalid, `locked`=0, `rdata`=0.
  - After release, requester 0 is granted immediately.
- Requester 0 store to 0x1000_0000.
  - `mem_we`=1 and `mem_addr`=0x1000_0000 in the same cycle; no rvalid follows.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter for the shared data-memory load/store port.
//   Requester 0 is the core load/store unit, requester 1 a secondary master
//   (debug/DMA). One access is granted per cycle, load data is registered and
//   returned to the winner one cycle later. Requester 0 wins contested cycles
//   up to CORE_BURST times in a row, then requester 1 gets one. Requester 1 may
//   lock the port for atomic read-modify-write sequences.
//
// Ports
//   clk, reset              system clock, synchronous active-low reset
//   m0_* / m1_*             request, address, size, store data, store strobe
//   m1_lock                 requester 1 keeps ownership after its grant
//   m0_gnt / m1_gnt         access accepted this cycle (combinational)
//   m0_rvalid / m1_rvalid   load data valid in rdata (one cycle after grant)
//   rdata                   registered load data, shared by both requesters
//   mem_*                   memory port (combinational read data in mem_rdata)
//
// Lock FSM
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_OPEN    | normal weighted arbitration between both requesters
//   ST_LOCKED  | requester 1 owns the port; requester 0 is never granted
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned CORE_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_bytes,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_bytes,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_lock,

    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] rdata,

    output logic [31:0] mem_addr,
    output logic [1:0]  mem_bytes,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    localparam logic [3:0] BURST_MAX = 4'(CORE_BURST);

    lock_state_t state, state_nxt;
    logic        locked;
    logic        contested;
    logic [3:0]  burst_cnt, burst_cnt_nxt;
    logic [1:0]  last_rd_owner;
    logic [31:0] rdata_q;

    assign locked    = (state == ST_LOCKED);
    assign contested = m0_req & m1_req;

    // Lock state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_OPEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision and lock next-state
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        state_nxt = state;

        if (reset) begin
            if (locked) begin
                // Requester 0 is shut out; with no m1_req the port idles.
                m1_gnt = m1_req;
            end else if (contested) begin
                if (burst_cnt < BURST_MAX) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end

        case (state)
            ST_OPEN: begin
                if (m1_gnt && m1_lock) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // The release cycle itself is still arbitrated as locked.
                if (!m1_lock) begin
                    state_nxt = ST_OPEN;
                end
            end
            default: state_nxt = ST_OPEN;
        endcase
    end

    // Fairness counter: counts consecutive contested wins of requester 0.
    always_comb begin
        burst_cnt_nxt = burst_cnt;
        if (!m1_req) begin
            burst_cnt_nxt = 4'd0;
        end else if (contested && m1_gnt) begin
            burst_cnt_nxt = 4'd0;
        end else if (contested && m0_gnt && (burst_cnt < BURST_MAX)) begin
            burst_cnt_nxt = burst_cnt + 4'd1;
        end
    end

    // Memory drive: requester 0 payload is the default so the core path
    // stays mux-free whenever requester 1 is not granted.
    always_comb begin
        mem_addr  = m0_addr;
        mem_bytes = m0_bytes;
        mem_wdata = m0_wdata;
        if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_bytes = m1_bytes;
            mem_wdata = m1_wdata;
        end
    end

    assign mem_we = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    assign mem_re = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

    // Counter, read-return owner and load data
    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt     <= 4'd0;
            last_rd_owner <= 2'b00;
            rdata_q       <= 32'd0;
        end else begin
            burst_cnt     <= burst_cnt_nxt;
            last_rd_owner <= {m1_gnt & ~m1_we, m0_gnt & ~m0_we};
            if (mem_re) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign m0_rvalid = last_rd_owner[0];
    assign m1_rvalid = last_rd_owner[1];
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A byte-addressed memory model serves
//   the DUT port; a separate shadow copy is updated from the granted requests
//   and supplies expected load data, which is queued at grant time and compared
//   when rvalid appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int unsigned CORE_BURST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic [1:0]  m0_bytes;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [1:0]  m1_bytes;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_bytes;
    logic        mem_we, mem_re;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    logic [7:0] mem    [0:255];
    logic [7:0] shadow [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.CORE_BURST(CORE_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_bytes  (m0_bytes),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_bytes  (m1_bytes),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_bytes (mem_bytes),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // Memory model: combinational word read, byte-lane write at the clock edge.
    always_comb begin
        int base;
        base = {24'd0, mem_addr[7:2], 2'b00};
        mem_rdata = {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
    end

    always @(posedge clk) begin
        int a;
        int wa;
        if (mem_we) begin
            a  = {24'd0, mem_addr[7:0]};
            wa = {24'd0, mem_addr[7:2], 2'b00};
            case (mem_bytes)
                2'b01: mem[a] = mem_wdata[7:0];
                2'b10: begin
                    mem[a]     = mem_wdata[7:0];
                    mem[a + 1] = mem_wdata[15:8];
                end
                default: begin
                    mem[wa]     = mem_wdata[7:0];
                    mem[wa + 1] = mem_wdata[15:8];
                    mem[wa + 2] = mem_wdata[23:16];
                    mem[wa + 3] = mem_wdata[31:24];
                end
            endcase
        end
    end

    function automatic logic [31:0] shadow_word(input logic [31:0] addr);
        int b;
        b = {24'd0, addr[7:2], 2'b00};
        return {shadow[b + 3], shadow[b + 2], shadow[b + 1], shadow[b]};
    endfunction

    task automatic shadow_store(input logic [31:0] addr, input logic [1:0] bytes,
                                input logic [31:0] wdata);
        int a;
        int wa;
        a  = {24'd0, addr[7:0]};
        wa = {24'd0, addr[7:2], 2'b00};
        case (bytes)
            2'b01: shadow[a] = wdata[7:0];
            2'b10: begin
                shadow[a]     = wdata[7:0];
                shadow[a + 1] = wdata[15:8];
            end
            default: begin
                shadow[wa]     = wdata[7:0];
                shadow[wa + 1] = wdata[15:8];
                shadow[wa + 2] = wdata[23:16];
                shadow[wa + 3] = wdata[31:24];
            end
        endcase
    endtask

    // Scoreboard: pop on rvalid, then push this cycle's load grants.
    always @(negedge clk) begin
        rd_exp_t e;
        if (m0_rvalid || m1_rvalid) begin
            if (sb_q.size() == 0) begin
                chk("rvalid_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rvalid_owner", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, e.owner});
                chk("rvalid_data", rdata, e.data);
            end
        end
        if (m0_gnt && !m0_we) sb_q.push_back('{2'b01, shadow_word(m0_addr)});
        if (m1_gnt && !m1_we) sb_q.push_back('{2'b10, shadow_word(m1_addr)});
        if (m0_gnt && m0_we) shadow_store(m0_addr, m0_bytes, m0_wdata);
        if (m1_gnt && m1_we) shadow_store(m1_addr, m1_bytes, m1_wdata);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [1:0] bytes, input logic [31:0] wdata);
        m0_req   = req;
        m0_we    = we;
        m0_addr  = addr;
        m0_bytes = bytes;
        m0_wdata = wdata;
    endtask

    task automatic drive1(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [1:0] bytes,
                          input logic [31:0] wdata);
        m1_req   = req;
        m1_we    = we;
        m1_lock  = lock;
        m1_addr  = addr;
        m1_bytes = bytes;
        m1_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
        shadow[16] = 8'hEF; shadow[17] = 8'hBE; shadow[18] = 8'hAD; shadow[19] = 8'hDE;

        reset = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        next_cycle();
        next_cycle();

        // Reset state, grants suppressed while reset is low
        drive0(1'b1, 1'b0, 32'h10, 2'b00, 32'h0);
        sample();
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_burst_cnt", 32'(dut.burst_cnt), 32'd0);
        next_cycle();

        // Single load from requester 0
        reset = 1'b1;
        sample();
        chk("ld0_gnt", 32'(m0_gnt), 32'd1);
        chk("ld0_mem_re", 32'(mem_re), 32'd1);
        chk("ld0_mem_addr", mem_addr, 32'h10);
        next_cycle();
        drive0(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        sample();
        chk("ld0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("ld0_rdata", rdata, 32'hDEADBEEF);
        chk("ld0_m1_rvalid", 32'(m1_rvalid), 32'd0);
        next_cycle();

        // Weighted fairness with both requesters loading continuously
        drive0(1'b1, 1'b0, 32'h40, 2'b00, 32'h0);
        drive1(1'b1, 1'b0, 1'b0, 32'h80, 2'b00, 32'h0);
        for (int i = 0; i < 14; i++) begin
            sample();
            chk("burst_cnt", 32'(dut.burst_cnt), 32'(i % 5));
            chk("burst_m0_gnt", 32'(m0_gnt), 32'((i % 5) != 4));
            chk("burst_m1_gnt", 32'(m1_gnt), 32'((i % 5) == 4));
            next_cycle();
        end

        // Locked sequence: load, store, load, then lock release
        drive1(1'b1, 1'b0, 1'b1, 32'h80, 2'b00, 32'h0);
        sample();
        chk("lock1_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("lock1_m1_gnt", 32'(m1_gnt), 32'd1);
        next_cycle();
        drive1(1'b1, 1'b1, 1'b1, 32'h84, 2'b00, 32'h11223344);
        sample();
        chk("lock2_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("lock2_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("lock2_mem_we", 32'(mem_we), 32'd1);
        next_cycle();
        drive1(1'b1, 1'b0, 1'b1, 32'h84, 2'b00, 32'h0);
        sample();
        chk("lock3_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("lock3_m1_gnt", 32'(m1_gnt), 32'd1);
        next_cycle();
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        sample();
        chk("unlock_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("unlock_idle", {30'd0, mem_we, mem_re}, 32'd0);
        chk("unlock_locked", 32'(dut.locked), 32'd1);
        next_cycle();
        sample();
        chk("after_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("after_locked", 32'(dut.locked), 32'd0);
        next_cycle();

        // Byte store from requester 1, then word load by requester 0
        drive0(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive1(1'b1, 1'b1, 1'b0, 32'h21, 2'b01, 32'h000000AB);
        sample();
        chk("stb_m1_gnt", 32'(m1_gnt), 32'd1);
        chk("stb_mem_we", 32'(mem_we), 32'd1);
        chk("stb_mem_bytes", 32'(mem_bytes), 32'd1);
        chk("stb_mem_addr", mem_addr, 32'h21);
        next_cycle();
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive0(1'b1, 1'b0, 32'h20, 2'b00, 32'h0);
        sample();
        chk("ldw_m0_gnt", 32'(m0_gnt), 32'd1);
        next_cycle();
        drive0(1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        sample();
        chk("ldw_rvalid", 32'(m0_rvalid), 32'd1);
        chk("ldw_byte1", {24'd0, rdata[15:8]}, 32'h000000AB);
        next_cycle();

        // Reset while locked right after a load grant
        drive1(1'b1, 1'b0, 1'b1, 32'h10, 2'b00, 32'h0);
        sample();
        chk("rl_m1_gnt", 32'(m1_gnt), 32'd1);
        next_cycle();
        reset = 1'b0;
        drive0(1'b1, 1'b0, 32'h40, 2'b00, 32'h0);
        sample();
        chk("rl_rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rl_rst_mem", {30'd0, mem_we, mem_re}, 32'd0);
        next_cycle();
        reset = 1'b1;
        sample();
        chk("rl_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("rl_locked", 32'(dut.locked), 32'd0);
        chk("rl_rdata", rdata, 32'd0);
        chk("rl_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rl_m1_gnt", 32'(m1_gnt), 32'd0);
        next_cycle();

        // Requester 0 store to a peripheral address
        drive1(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        drive0(1'b1, 1'b1, 32'h1000_0000, 2'b00, 32'hCAFEF00D);
        sample();
        chk("st0_mem_we", 32'(mem_we), 32'd1);
        chk("st0_mem_re", 32'(mem_re), 32'd0);
        chk("st0_mem_addr", mem_addr, 32'h1000_0000);
        chk("st0_mem_wdata", mem_wdata, 32'hCAFEF00D);
        next_cycle();

        // Idle: port follows requester 0 payload, no response to the store
        drive0(1'b0, 1'b0, 32'h0000_0044, 2'b10, 32'h5555AAAA);
        drive1(1'b0, 1'b1, 1'b0, 32'h0000_0088, 2'b01, 32'h12345678);
        sample();
        chk("idle_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'h0000_0044);
        chk("idle_mem_bytes", 32'(mem_bytes), 32'd2);
        chk("idle_mem_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        next_cycle();
        next_cycle();
        sample();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
